// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path: default sample width,
// capture state encoding and buffer depth derivation.
package la_pkg;

  // Default sample width, kept in step with DATA_WIDTH in define.v.
  localparam int LA_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_READ  = 3'd5
  } la_state_t;

  function automatic int la_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/trigger_match.sv
// Masked-value trigger comparator; force_trig overrides the compare.
module trigger_match
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  force_trig,
  output logic                  match
);

  assign match = (((data ^ value) & mask) == '0) || force_trig;

endmodule

// File: rtl/capture_controller.sv
// Logic-analyzer capture sequencer: ring-buffer pre-trigger fill, trigger detect,
// post-trigger count, then chronological readout of the captured window.
module capture_controller
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = LA_DATA_WIDTH,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  rd_next,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int                  DEPTH    = la_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1 = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_L  = (ADDR_WIDTH+1)'(1);

  la_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, fill_cnt, pre_l, post_eff, remaining, rd_ptr;
  logic [ADDR_WIDTH:0]   rd_left;
  logic                  rd_last_p0;
  logic                  match;
  logic                  arm_go, capture, trig_hit, rd_enter, rd_issue;

  // Limit the post-trigger count so pre + post + 1 never exceeds the ring.
  function automatic logic [ADDR_WIDTH-1:0] clamp_post(input logic [ADDR_WIDTH-1:0] pre,
                                                       input logic [ADDR_WIDTH-1:0] post);
    logic [ADDR_WIDTH:0] room;
    room = DEPTH_M1 - {1'b0, pre};
    if ({1'b0, post} > room) return room[ADDR_WIDTH-1:0];
    return post;
  endfunction

  function automatic logic [ADDR_WIDTH:0] win_len(input logic [ADDR_WIDTH-1:0] pre,
                                                  input logic [ADDR_WIDTH-1:0] post);
    return {1'b0, pre} + {1'b0, post} + ONE_L;
  endfunction

  trigger_match #(.DATA_WIDTH(DATA_WIDTH)) u_trigger_match (
    .data       (i_data),
    .mask       (trig_mask),
    .value      (trig_value),
    .force_trig (force_trig),
    .match      (match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    capture   = 1'b0;
    trig_hit  = 1'b0;
    rd_enter  = 1'b0;
    rd_issue  = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            arm_go    = 1'b1;
            state_nxt = (pre_count == '0) ? ST_ARMED : ST_FILL;
          end
        end
        ST_FILL: begin
          capture = 1'b1;
          if (fill_cnt + ONE_A == pre_l) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          capture = 1'b1;
          if (match) begin
            trig_hit  = 1'b1;
            state_nxt = (post_eff == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          capture = 1'b1;
          if (remaining == ONE_A) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (arm) begin
            arm_go    = 1'b1;
            state_nxt = (pre_count == '0) ? ST_ARMED : ST_FILL;
          end else if (rd_next) begin
            rd_enter  = 1'b1;
            state_nxt = ST_READ;
          end
        end
        ST_READ: begin
          if (rd_next) begin
            rd_issue = 1'b1;
            if (rd_left == ONE_L) state_nxt = ST_DONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Capture stage: RAM write port and ring bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      fill_cnt  <= '0;
      pre_l     <= '0;
      post_eff  <= '0;
      remaining <= '0;
      trig_addr <= '0;
    end else begin
      wr_en <= capture;
      if (arm_go) begin
        ptr      <= '0;
        fill_cnt <= '0;
        pre_l    <= pre_count;
        post_eff <= clamp_post(pre_count, post_count);
      end
      if (capture) begin
        wr_addr <= ptr;
        wr_data <= i_data;
        ptr     <= ptr + ONE_A;
      end
      if (capture && state == ST_FILL) fill_cnt <= fill_cnt + ONE_A;
      if (trig_hit) begin
        trig_addr <= ptr;
        remaining <= post_eff;
      end
      if (capture && state == ST_POST) remaining <= remaining - ONE_A;
    end
  end

  // Readout stage p0: read request; p1: RAM data on the bus with o_valid/o_last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      rd_left     <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      rd_last_p0  <= 1'b0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
    end else begin
      if (rd_enter) begin
        rd_ptr  <= trig_addr - pre_l;
        rd_left <= win_len(pre_l, post_eff);
      end
      mem_rd_en  <= rd_issue;
      rd_last_p0 <= rd_issue && (rd_left == ONE_L);
      if (rd_issue) begin
        mem_rd_addr <= rd_ptr;
        rd_ptr      <= rd_ptr + ONE_A;
        rd_left     <= rd_left - ONE_L;
      end
      o_valid <= mem_rd_en;
      o_last  <= rd_last_p0;
    end
  end

  assign busy = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST) || (state == ST_READ);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_capture_controller.sv
// Randomised scoreboard bench for capture_controller with a sample-RAM model.
module tb_capture_controller;
  import la_pkg::*;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0, abort = 1'b0, force_trig = 1'b0, rd_next = 1'b0;
  logic [DW-1:0] trig_mask = '0, trig_value = '0, i_data = '0;
  logic [AW-1:0] pre_count = '0, post_count = '0;
  logic          wr_en, mem_rd_en, o_valid, o_last, busy, done;
  logic [AW-1:0] wr_addr, mem_rd_addr, trig_addr;
  logic [DW-1:0] wr_data;

  capture_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_mask(trig_mask), .trig_value(trig_value), .pre_count(pre_count),
    .post_count(post_count), .i_data(i_data), .rd_next(rd_next),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .o_valid(o_valid),
    .o_last(o_last), .trig_addr(trig_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port sample RAM, one-cycle read latency
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_data = '0;
  always @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    if (mem_rd_en) rd_data <= ram[mem_rd_addr];
  end

  typedef struct packed {logic [DW-1:0] data; logic last;} word_t;
  word_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int last_seen = 0;

  // Reference-model state of the most recent capture
  logic [DW-1:0] hist[$];
  int m_pre, m_post_eff, m_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    word_t w;
    if (wr_en) wr_count++;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("read_data", int'(rd_data), int'(w.data));
        check("read_last", int'(o_last), int'(w.last));
        if (o_last) last_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] gen(input int mode, input int k, input logic [DW-1:0] v);
    logic [DW-1:0] d;
    d = DW'($urandom);
    if (mode == 1) d = (k == 20) ? 8'hA5 : DW'(k);
    else if (mode == 2 && d == v) d = d ^ 8'h01;
    return d;
  endfunction

  // mode 0: random data with random force/arm/rd_next noise; 1: ramp with A5 at 20;
  // 2: random data that never equals the trigger value
  task automatic run_capture(input int pre, input int post, input logic [DW-1:0] mask,
                             input logic [DW-1:0] value, input int force_at, input int mode);
    int post_eff, t, end_k, wbase;
    logic [DW-1:0] d;
    post_eff = (post < DEPTH - 1 - pre) ? post : DEPTH - 1 - pre;
    t = -1;
    end_k = -1;
    hist.delete();
    arm = 1'b1; pre_count = AW'(pre); post_count = AW'(post);
    trig_mask = mask; trig_value = value; force_trig = 1'b0;
    tick();
    arm = 1'b0;
    wbase = wr_count;
    for (int k = 0; ; k++) begin
      d = gen(mode, k, value);
      i_data = d;
      force_trig = (k == force_at) || (mode == 0 && $urandom_range(0, 63) == 0);
      arm = (mode == 0) && ($urandom_range(0, 31) == 0);
      rd_next = (mode == 0) && ($urandom_range(0, 7) == 0);
      hist.push_back(d);
      if (t < 0 && k >= pre && ((((d ^ value) & mask) == '0) || force_trig)) begin
        t = k;
        end_k = t + post_eff;
      end
      if (k == end_k) check("done_before_last", int'(done), 0);
      tick();
      if (k == end_k) break;
      if (k > 3000) begin
        check("capture_timeout", k, -1);
        arm = 1'b0; rd_next = 1'b0; force_trig = 1'b0;
        return;
      end
    end
    arm = 1'b0; rd_next = 1'b0; force_trig = 1'b0;
    check("done_after_last", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
    check("trig_addr", int'(trig_addr), t % DEPTH);
    tick();
    check("wr_en_after_done", int'(wr_en), 0);
    check("write_count", wr_count - wbase, end_k + 1);
    m_pre = pre; m_post_eff = post_eff; m_t = t;
  endtask

  task automatic push_window();
    int len;
    len = m_pre + m_post_eff + 1;
    for (int i = 0; i < len; i++)
      exp_q.push_back('{data: hist[m_t - m_pre + i], last: (i == len - 1)});
  endtask

  task automatic read_window(input bit gaps);
    int len, req, ls0;
    len = m_pre + m_post_eff + 1;
    req = 0;
    ls0 = last_seen;
    push_window();
    rd_next = 1'b1;
    tick();
    while (req < len) begin
      rd_next = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rd_next) req++;
      tick();
    end
    rd_next = 1'b0;
    repeat (4) tick();
    check("readout_last_count", last_seen - ls0, 1);
    check("readout_drained", exp_q.size(), 0);
    check("done_after_read", int'(done), 1);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int flag;
    #1 reset = 1'b0;
    repeat (2) tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_mem_rd_en", int'(mem_rd_en), 0);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_trig_addr", int'(trig_addr), 0);
    reset = 1'b1;
    tick();

    // Ramp with A5 at sample 20
    run_capture(4, 3, 8'hFF, 8'hA5, -1, 1);
    read_window(1'b0);
    read_window(1'b1);

    // Immediate trigger, single-sample window
    run_capture(0, 0, 8'h00, 8'h00, -1, 2);
    read_window(1'b0);

    // Ring wrap: trigger at sample 600 lands at address 88
    run_capture(10, 5, 8'hFF, 8'h3C, 600, 2);
    check("wrap_start", (m_t - m_pre) % DEPTH, 78);
    read_window(1'b1);

    // Clamp: post shrinks to 11, window fills the ring
    run_capture(500, 100, 8'hFF, 8'h77, 510, 2);
    check("clamp_post", m_post_eff, 11);
    read_window(1'b0);

    // Abort mid-POST, then arm together with abort
    arm = 1'b1; pre_count = 9'd2; post_count = 9'd50; trig_mask = 8'h00; trig_value = 8'h00;
    tick();
    arm = 1'b0;
    repeat (10) tick();
    check("post_busy", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_trig_held", int'(trig_addr), 2);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_busy", int'(busy), 0);
    run_capture(3, 4, 8'hF0, 8'h50, 9, 2);
    read_window(1'b1);

    // Asynchronous reset in the middle of a readout
    run_capture(8, 8, 8'hFF, 8'hC3, 12, 2);
    push_window();
    rd_next = 1'b1;
    repeat (4) tick();
    #1 reset = 1'b0;
    #1;
    check("ar_wr_en", int'(wr_en), 0);
    check("ar_mem_rd_en", int'(mem_rd_en), 0);
    check("ar_o_valid", int'(o_valid), 0);
    check("ar_o_last", int'(o_last), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_done", int'(done), 0);
    check("ar_trig_addr", int'(trig_addr), 0);
    check("ar_mem_rd_addr", int'(mem_rd_addr), 0);
    exp_q.delete();
    #2 reset = 1'b1;
    flag = 0;
    repeat (10) begin
      tick();
      if (mem_rd_en || o_valid || busy) flag = 1;
    end
    rd_next = 1'b0;
    check("ar_no_read_after_release", flag, 0);

    // Randomised captures
    for (int r = 0; r < 8; r++) begin
      int pre, post;
      pre  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 40));
      post = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 40));
      run_capture(pre, post, DW'($urandom), DW'($urandom), pre + int'($urandom_range(0, 30)), 0);
      read_window(r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
# capture_controller

Sequences one logic-analyzer capture around the delayed sample stream. It arms on command and fills a circular sample buffer with pre-trigger history. It detects a masked-value trigger, then counts post-trigger samples and stops. It then streams the captured window back out of the buffer in chronological order. It sits between the `delay` line output and the single-port sample RAM, and is the only block that drives RAM addresses.

## Interface
- `DATA_WIDTH`, default 8: sample width; equals `` `DATA_WIDTH `` from `define.v`.
- `ADDR_WIDTH`, default 9: buffer address width; DEPTH = 2^ADDR_WIDTH.
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs immediately.
- `arm`  in  1  start a capture; honoured only in IDLE or DONE.
- `abort`  in  1  return to IDLE from any state; wins over every other input.
- `force_trig`  in  1  treat the current sample as a trigger match (ARMED only).
- `trig_mask`, `trig_value`  in  DATA_WIDTH  match when ((i_data ^ trig_value) & trig_mask) == 0.
- `pre_count`  in  ADDR_WIDTH  pre-trigger samples to keep; latched on arm.
- `post_count`  in  ADDR_WIDTH  samples after the trigger sample; latched on arm, then clamped.
- `i_data`  in  DATA_WIDTH  sample from the delay line, valid every cycle.
- `rd_next`  in  1  request the next readout word (DONE or READ).
- `wr_en`, `wr_addr`, `wr_data`  out  1/ADDR_WIDTH/DATA_WIDTH  registered RAM write port.
- `mem_rd_en`, `mem_rd_addr`  out  1/ADDR_WIDTH  RAM read request; RAM returns data one cycle later.
- `o_valid`  out  1  RAM read data on the bus is a readout word (registered `mem_rd_en`).
- `o_last`  out  1  with `o_valid`, marks the final word of the window.
- `trig_addr`  out  ADDR_WIDTH  buffer address of the trigger sample.
- `busy`, `done`  out  1  busy = FILL/ARMED/POST/READ; done = DONE.

## Operation
- States are IDLE, FILL, ARMED, POST, DONE and READ.
- IDLE → FILL on `arm`. If the latched `pre_count` is 0, go straight to ARMED. DONE → FILL/ARMED on `arm` re-arms; the previous capture is lost.
- FILL/ARMED/POST capture every cycle:
  - `wr_en`<=1, `wr_data`<=i_data, `wr_addr`<=ptr, then ptr <= ptr+1 mod DEPTH.
  - ptr resets to 0 on every arm.
- FILL counts captures. After the pre_count-th capture it moves to ARMED. The trigger is ignored in FILL.
- ARMED keeps capturing and overwriting the ring. On the first match or `force_trig`:
  - that sample is written; `trig_addr`<=its address; remaining<=post_eff.
  - Next state is POST, or DONE if post_eff==0.
- POST captures and decrements remaining. The capture that brings it to 0 is the last one; next state is DONE.
- Clamp rule: post_eff = min(post_count, DEPTH-1-pre_count), computed in ADDR_WIDTH+1 bits. This keeps the window ≤ DEPTH.
- Window length is L = pre_count + post_eff + 1. Start address S = (trig_addr − pre_count) mod DEPTH.
- DONE → READ on `rd_next`. On entry, rd_ptr=S and rd_left=L.
- In READ, each cycle with `rd_next`=1 issues `mem_rd_en`=1, `mem_rd_addr`=rd_ptr, then rd_ptr+1 mod DEPTH and rd_left−1.
- After the word with rd_left==1 is issued, the state returns to DONE; the window can be re-read. `rd_next` in any other state is ignored.
- `abort` → IDLE next edge. `wr_en`/`mem_rd_en` are 0 from that edge; trig_addr is held.
- Outputs after reset: all 0, state IDLE.

## Timing
- `arm` sampled at edge E0; first write registered at E1; RAM writes at E2.
- The trigger decision uses i_data of the same edge at which that sample is captured. There is no extra delay; upstream `delay` latency is not compensated here.
- DONE is visible (`done`=1) the edge after the final POST capture. `wr_en` is low that same edge.
- Readout: `rd_next` at edge R issues `mem_rd_en`. `o_valid` is high for the cycle after R+1, with RAM data on the bus. `o_last` accompanies the L-th word.
- `arm` together with `abort` resolves to IDLE. `arm` during FILL/ARMED/POST/READ is ignored.

## Structure
- Shared package `la_pkg` holds the state encoding (3-bit, named constants) and the DEPTH derivation. `DATA_WIDTH` continues to come from `define.v`.
- One sub-module: `trigger_match` (combinational mask/value compare plus `force_trig` OR). All counters and pointers stay in `capture_controller`.

## Test plan
- DEPTH=512, pre=4, post=3, trig_mask=FF, value=A5. Feed ramp 0x00.., with A5 at sample 20.
  - Expect trig_addr=20 and done after 24 writes.
  - Readout yields 16,17,18,19,A5,21,22,23; o_last on the 8th word.
- pre=0, post=0, mask=00 → triggers on the first sample. Expect one write, L=1, readout of 1 word with o_last.
- Ring wrap: pre=10, trigger at sample 600 (ptr=88). Expect S=78 and readout of samples 590..600+post in order.
- Clamp: pre=500, post=100 → post_eff=11. Expect DONE after exactly 11 post captures and L=512.
- `abort` mid-POST. Expect IDLE next edge, `wr_en`=0. A re-arm restarts at ptr 0.
- Async reset asserted mid-READ. Expect all outputs 0 immediately; `mem_rd_en` stays 0 after release until a new capture completes.
